// File: rtl/bridge_pkg.sv
// Shared op codes, exception codes, address map defaults and timer definitions
// for the CPU data-port bridge.
package bridge_pkg;

  localparam logic [2:0] SOP_NONE = 3'd0;
  localparam logic [2:0] SOP_SW   = 3'd1;
  localparam logic [2:0] SOP_SH   = 3'd2;
  localparam logic [2:0] SOP_SB   = 3'd3;

  localparam logic [2:0] LOP_NONE = 3'd0;
  localparam logic [2:0] LOP_LW   = 3'd1;
  localparam logic [2:0] LOP_LH   = 3'd2;
  localparam logic [2:0] LOP_LHU  = 3'd3;
  localparam logic [2:0] LOP_LB   = 3'd4;
  localparam logic [2:0] LOP_LBU  = 3'd5;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DM_TOP_DEF   = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7F10;
  localparam logic [31:0] TC_SPAN      = 32'd12;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, IRQ} tc_state_e;

endpackage

// File: rtl/sys_bridge_if.sv
// CPU M-stage data port: request fields from the CPU, load data and exception back.
interface sys_bridge_if;
  logic [31:0] mem_addr;
  logic [2:0]  mem_sop;
  logic [2:0]  mem_lop;
  logic [31:0] mem_wdata;
  logic        mem_flush;
  logic [31:0] mem_rdata;
  logic [4:0]  mem_ec;

  modport master (
    output mem_addr, mem_sop, mem_lop, mem_wdata, mem_flush,
    input  mem_rdata, mem_ec
  );

  modport slave (
    input  mem_addr, mem_sop, mem_lop, mem_wdata, mem_flush,
    output mem_rdata, mem_ec
  );
endinterface

// File: rtl/timer_counter.sv
// One countdown timer: CTRL/PRESET/COUNT registers, IDLE/LOAD/CNT/IRQ FSM
// and a registered interrupt output.
module timer_counter
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we_ctrl,
  input  logic        i_we_preset,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ctrl,
  output logic [31:0] o_preset,
  output logic [31:0] o_count,
  output logic        o_irq
);

  tc_state_e   r_state;
  tc_state_e   w_state_next;
  logic [3:0]  r_ctrl;
  logic [3:0]  w_ctrl_next;
  logic [31:0] r_preset;
  logic [31:0] w_preset_next;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        r_flag;
  logic        w_flag_next;
  logic        r_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_flag   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ctrl   <= w_ctrl_next;
      r_preset <= w_preset_next;
      r_count  <= w_count_next;
      r_flag   <= w_flag_next;
      r_irq    <= w_flag_next & w_ctrl_next[CTRL_IM];
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_ctrl_next   = r_ctrl;
    w_preset_next = r_preset;
    w_count_next  = r_count;
    w_flag_next   = r_flag;
    // A CPU write wins over any timer event and restarts the FSM from IDLE.
    if (i_we_ctrl || i_we_preset) begin
      if (i_we_ctrl)   w_ctrl_next   = i_wdata[3:0];
      if (i_we_preset) w_preset_next = i_wdata;
      w_flag_next  = 1'b0;
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (r_ctrl[CTRL_EN]) w_state_next = LOAD;
        LOAD: begin
          w_count_next = r_preset;
          w_state_next = CNT;
        end
        CNT: begin
          if (!r_ctrl[CTRL_EN]) begin
            w_state_next = IDLE;
          end else if (r_count > 32'd1) begin
            w_count_next = r_count - 32'd1;
          end else begin
            w_count_next = 32'd0;
            w_flag_next  = 1'b1;
            w_state_next = IRQ;
          end
        end
        IRQ: begin
          if (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == 2'd1) begin
            w_state_next = LOAD;
          end else begin
            w_ctrl_next[CTRL_EN] = 1'b0;
            w_state_next         = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign o_ctrl   = {28'd0, r_ctrl};
  assign o_preset = r_preset;
  assign o_count  = r_count;
  assign o_irq    = r_irq;

endmodule

// File: rtl/sys_bridge.sv
// Memory-side responder for the CPU data port: address decode, store lane
// generation, load extraction and two memory-mapped countdown timers.
module sys_bridge
  import bridge_pkg::*;
#(
  parameter logic [31:0] DM_TOP   = DM_TOP_DEF,
  parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
  parameter logic [31:0] TC1_BASE = TC1_BASE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  sys_bridge_if.slave  cpu,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_byteen,
  output logic [31:0]  dm_wdata,
  input  logic [31:0]  dm_rdata,
  input  logic         ext_int,
  output logic [5:0]   hw_int
);

  logic        w_is_load, w_is_store, w_is_word, w_is_half;
  logic        w_misalign, w_in_dm, w_in_tc0, w_in_tc1, w_in_tc, w_bad, w_commit;
  logic [31:0] w_off0, w_off1;
  logic [1:0]  w_tc_reg;
  logic [3:0]  w_lanes;
  logic [31:0] w_tc_rd, w_src, w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_we_ctrl0, w_we_preset0, w_we_ctrl1, w_we_preset1;
  logic [31:0] w_ctrl0, w_preset0, w_count0, w_ctrl1, w_preset1, w_count1;
  logic        w_irq0, w_irq1;

  assign w_is_load  = (cpu.mem_lop != LOP_NONE) && (cpu.mem_lop <= LOP_LBU);
  assign w_is_store = (cpu.mem_sop != SOP_NONE) && (cpu.mem_sop <= SOP_SB);
  assign w_is_word  = (cpu.mem_lop == LOP_LW) || (cpu.mem_sop == SOP_SW);
  assign w_is_half  = (cpu.mem_lop == LOP_LH) || (cpu.mem_lop == LOP_LHU) ||
                      (cpu.mem_sop == SOP_SH);
  assign w_misalign = (w_is_word && (cpu.mem_addr[1:0] != 2'b00)) ||
                      (w_is_half && cpu.mem_addr[0]);

  // Offsets wrap below the base, so one unsigned compare covers both bounds.
  assign w_off0   = cpu.mem_addr - TC0_BASE;
  assign w_off1   = cpu.mem_addr - TC1_BASE;
  assign w_in_dm  = (cpu.mem_addr <= DM_TOP);
  assign w_in_tc0 = (w_off0 < TC_SPAN);
  assign w_in_tc1 = (w_off1 < TC_SPAN);
  assign w_in_tc  = w_in_tc0 || w_in_tc1;
  assign w_tc_reg = w_in_tc1 ? w_off1[3:2] : w_off0[3:2];

  assign w_bad = w_misalign || !(w_in_dm || w_in_tc) ||
                 (w_in_tc && !w_is_word) ||
                 (w_in_tc && w_is_store && (w_tc_reg == 2'd2));

  assign cpu.mem_ec = (w_is_load  && w_bad) ? EXC_ADEL :
                      (w_is_store && w_bad) ? EXC_ADES : EXC_NONE;

  assign w_commit = w_is_store && !w_bad && !cpu.mem_flush;

  always_comb begin
    w_lanes  = 4'b0000;
    dm_wdata = cpu.mem_wdata;
    case (cpu.mem_sop)
      SOP_SW: w_lanes = 4'b1111;
      SOP_SH: begin
        w_lanes  = cpu.mem_addr[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{cpu.mem_wdata[15:0]}};
      end
      SOP_SB: begin
        w_lanes  = 4'b0001 << cpu.mem_addr[1:0];
        dm_wdata = {4{cpu.mem_wdata[7:0]}};
      end
      default: w_lanes = 4'b0000;
    endcase
  end

  assign dm_addr   = {cpu.mem_addr[31:2], 2'b00};
  assign dm_byteen = (reset && w_commit && w_in_dm) ? w_lanes : 4'b0000;

  assign w_we_ctrl0   = w_commit && w_in_tc0 && (w_tc_reg == 2'd0);
  assign w_we_preset0 = w_commit && w_in_tc0 && (w_tc_reg == 2'd1);
  assign w_we_ctrl1   = w_commit && w_in_tc1 && (w_tc_reg == 2'd0);
  assign w_we_preset1 = w_commit && w_in_tc1 && (w_tc_reg == 2'd1);

  timer_counter u_tc0 (
    .clk         (clk),
    .reset       (reset),
    .i_we_ctrl   (w_we_ctrl0),
    .i_we_preset (w_we_preset0),
    .i_wdata     (cpu.mem_wdata),
    .o_ctrl      (w_ctrl0),
    .o_preset    (w_preset0),
    .o_count     (w_count0),
    .o_irq       (w_irq0)
  );

  timer_counter u_tc1 (
    .clk         (clk),
    .reset       (reset),
    .i_we_ctrl   (w_we_ctrl1),
    .i_we_preset (w_we_preset1),
    .i_wdata     (cpu.mem_wdata),
    .o_ctrl      (w_ctrl1),
    .o_preset    (w_preset1),
    .o_count     (w_count1),
    .o_irq       (w_irq1)
  );

  always_comb begin
    case (w_tc_reg)
      2'd0:    w_tc_rd = w_in_tc1 ? w_ctrl1   : w_ctrl0;
      2'd1:    w_tc_rd = w_in_tc1 ? w_preset1 : w_preset0;
      default: w_tc_rd = w_in_tc1 ? w_count1  : w_count0;
    endcase
  end

  assign w_src  = w_in_dm ? dm_rdata : w_tc_rd;
  assign w_half = cpu.mem_addr[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    case (cpu.mem_addr[1:0])
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_is_load && !w_bad) begin
      case (cpu.mem_lop)
        LOP_LW:  w_rdata = w_src;
        LOP_LH:  w_rdata = {{16{w_half[15]}}, w_half};
        LOP_LHU: w_rdata = {16'd0, w_half};
        LOP_LB:  w_rdata = {{24{w_byte[7]}}, w_byte};
        LOP_LBU: w_rdata = {24'd0, w_byte};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  assign cpu.mem_rdata = w_rdata;
  assign hw_int        = {3'b000, ext_int, w_irq1, w_irq0};

endmodule
